fp_add_arb_ctrl: RTL and testbench

FP_ADD_ARB_CTRL -- requirements
Module: fp_add_arb_ctrl

---
 rtl/fp_add_arb_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fp_add_arb_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arb_ctrl.sv
// -----------------------------------------------------------------------------
// fp_add_arb_ctrl
//
// Purpose:
//   Two-requester round-robin arbiter and sequencing FSM for a small 8-bit
//   floating-point adder datapath. It grants one requester, steps the datapath
//   through LOAD / ALIGN / ADD / NORM / ROUND / OUT / DONE, and returns the sum.
//   If normalisation takes more than NORM_MAX cycles, the operation is aborted
//   and returns 8'hFF with err set.
//
// Handshake:
//   req0/req1 are levels. A requester raises req and holds it until its done
//   pulse. gntX is high from LOAD through DONE. doneX is a one-cycle pulse, and
//   result/err are valid in that same cycle. Dropping req after the grant does
//   not cancel the operation.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   req0/req1           request levels
//   a0,b0 / a1,b1       operands {sign, exp[3:0], mant[2:0]}
//   gnt0/gnt1           grant, LOAD..DONE
//   done0/done1         completion pulse
//   result, err         sum (or 8'hFF) and abort flag, held until next DONE
//   busy                high in every state except IDLE
//   dp_a, dp_b          operands from the granted requester (captured in LOAD)
//   dp_state            datapath phase code
//   dp_en_a/dp_en_b     operand load enables (LOAD)
//   dp_en_round         round enable (ROUND)
//   dp_valid            sum-register write enable (OUT)
//   dp_normalize        datapath: mantissa normalised or exponent over/underflow
//   dp_sum              datapath sum register
//   dbg_state           raw FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module fp_add_arb_ctrl #(
   parameter int NORM_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] result,
   output logic       err,
   output logic       busy,
   output logic [7:0] dp_a,
   output logic [7:0] dp_b,
   output logic [2:0] dp_state,
   output logic       dp_en_a,
   output logic       dp_en_b,
   output logic       dp_en_round,
   output logic       dp_valid,
   input  logic       dp_normalize,
   input  logic [7:0] dp_sum,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ALIGN = 3'd2,
      S_ADD   = 3'd3,
      S_NORM  = 3'd4,
      S_ROUND = 3'd5,
      S_OUT   = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   localparam logic [2:0] LP_NORM_MAX = 3'(NORM_MAX);

   state_t     r_state;
   state_t     w_next;
   logic       r_sel;       // granted requester: 0 = req0, 1 = req1
   logic       r_last;      // last served requester
   logic       r_err;
   logic [2:0] r_norm_cnt;  // index of the current NORM cycle (1-based)
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_result;

   logic       w_any_req;
   logic       w_pick;
   logic       w_abort;
   logic [7:0] w_op_a;
   logic [7:0] w_op_b;

   assign w_any_req = req0 | req1;
   // With both requesting, the one not served last wins; a lone request wins.
   assign w_pick    = (req0 & req1) ? ~r_last : req1;
   assign w_op_a    = r_sel ? a1 : a0;
   assign w_op_b    = r_sel ? b1 : b0;
   // A normalised result in the same cycle as the limit takes the normal exit.
   assign w_abort   = (r_state == S_NORM) && !dp_normalize &&
                      (r_norm_cnt == LP_NORM_MAX);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_LOAD;
         S_LOAD:  w_next = S_ALIGN;
         S_ALIGN: w_next = S_ADD;
         S_ADD:   w_next = S_NORM;
         S_NORM: begin
            if (dp_normalize)  w_next = S_ROUND;
            else if (w_abort)  w_next = S_DONE;
            else               w_next = S_NORM;
         end
         S_ROUND: w_next = S_OUT;
         S_OUT:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_sel      <= 1'b0;
         r_last     <= 1'b1;   // req0 is favoured by the first arbitration
         r_err      <= 1'b0;
         r_norm_cnt <= 3'd0;
         r_a        <= 8'h00;
         r_b        <= 8'h00;
         r_result   <= 8'h00;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_any_req) begin
            r_sel  <= w_pick;
            r_last <= w_pick;
         end
         if (r_state == S_LOAD) begin
            r_a        <= w_op_a;
            r_b        <= w_op_b;
            r_norm_cnt <= 3'd0;
         end
         if (r_state == S_ADD || (r_state == S_NORM && w_next == S_NORM)) begin
            r_norm_cnt <= r_norm_cnt + 3'd1;
         end
         // err/abort value is fixed on entry to DONE so both are valid with done.
         if (w_next == S_DONE) begin
            r_err <= w_abort;
            if (w_abort) r_result <= 8'hFF;
         end
         if (r_state == S_DONE && !r_err) begin
            r_result <= dp_sum;
         end
      end
   end

   always_comb begin
      busy        = (r_state != S_IDLE);
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      done0       = 1'b0;
      done1       = 1'b0;
      dp_en_a     = 1'b0;
      dp_en_b     = 1'b0;
      dp_en_round = 1'b0;
      dp_valid    = 1'b0;
      dp_a        = r_a;
      dp_b        = r_b;
      dp_state    = 3'b000;
      result      = r_result;
      err         = r_err;
      dbg_state   = r_state;

      if (busy) begin
         gnt0 = ~r_sel;
         gnt1 = r_sel;
      end

      case (r_state)
         S_LOAD: begin
            dp_en_a = 1'b1;
            dp_en_b = 1'b1;
            // Operands pass straight through while they are being loaded.
            dp_a    = w_op_a;
            dp_b    = w_op_b;
         end
         S_ALIGN: dp_state = 3'b001;
         S_ADD:   dp_state = 3'b010;
         S_NORM:  dp_state = 3'b011;
         S_ROUND: begin
            dp_state    = 3'b100;
            dp_en_round = 1'b1;
         end
         S_OUT: begin
            dp_state = 3'b101;
            dp_valid = 1'b1;
         end
         S_DONE: begin
            done0 = ~r_sel;
            done1 = r_sel;
            // The sum register is presented directly so it is valid with done.
            if (!r_err) result = dp_sum;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fp_add_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_add_arb_ctrl
//
// Bench for fp_add_arb_ctrl. A datapath stub drives dp_normalize/dp_sum.
// The expected grant, latency, result and err values come from a small
// reference model:
//   - winner: the requester not served last, or the lone requester
//   - done offset from LOAD: 5+n for a normal exit, 3+NORM_MAX for an abort
//   - grant length: done offset + 1
//   - result: stub sum, or 8'hFF with err=1 on abort
// -----------------------------------------------------------------------------
module tb_fp_add_arb_ctrl;
  localparam int NORM_MAX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, err, busy;
  logic [7:0] result, dp_a, dp_b;
  logic [2:0] dp_state, dbg_state;
  logic       dp_en_a, dp_en_b, dp_en_round, dp_valid;
  logic       dp_normalize = 1'b0;
  logic [7:0] dp_sum = 8'h00;

  fp_add_arb_ctrl #(.NORM_MAX(NORM_MAX)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_state(dp_state),
    .dp_en_a(dp_en_a), .dp_en_b(dp_en_b), .dp_en_round(dp_en_round),
    .dp_valid(dp_valid), .dp_normalize(dp_normalize), .dp_sum(dp_sum),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / model ----------------
  int checks = 0;
  int errors = 0;
  bit model_last = 1'b1;   // last served requester; reset favours req0

  function automatic int win(input bit r0, input bit r1);
    int w;
    if (r0 && r1) w = model_last ? 0 : 1;
    else          w = r1 ? 1 : 0;
    model_last = (w == 1);
    return w;
  endfunction

  function automatic int exp_done(input int n);
    return (n == 0) ? 3 + NORM_MAX : 5 + n;
  endfunction

  // ---------------- observations from one operation ----------------
  int         ob_g, ob_load, ob_done, ob_gnt, ob_en, ob_rnd, ob_vld, ob_dcnt;
  logic [7:0] ob_res, ob_la, ob_lb;
  logic       ob_err;
  bit         ob_both, ob_moved, ob_wrong;

  // Runs one operation from an IDLE cycle to its DONE cycle. The stub reports
  // normalised on NORM cycle n_norm (0 = never). Returns at the DONE negedge.
  task automatic run_op(input int n_norm, input logic [7:0] sum_val,
                        input bit release_after, input bit drop_at_add,
                        input bit change_at_align);
    int cyc = 0;
    int norm_seen = 0;
    bit fin = 0;
    ob_g = -1; ob_load = -1; ob_done = -1; ob_gnt = 0; ob_en = 0;
    ob_rnd = 0; ob_vld = 0; ob_dcnt = 0; ob_res = 8'hxx; ob_err = 1'bx;
    ob_la = 8'hxx; ob_lb = 8'hxx; ob_both = 0; ob_moved = 0; ob_wrong = 0;
    dp_sum = sum_val;
    dp_normalize = 1'b0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt0 && gnt1) ob_both = 1;
      if (busy && ob_load < 0) begin
        ob_load = cyc;
        ob_g    = gnt1 ? 1 : (gnt0 ? 0 : -1);
        ob_la   = dp_a;
        ob_lb   = dp_b;
      end else if (busy && (dp_a !== ob_la || dp_b !== ob_lb)) begin
        ob_moved = 1;
      end
      if (gnt0 || gnt1)       ob_gnt++;
      if (dp_en_a && dp_en_b) ob_en++;
      if (dp_en_round)        ob_rnd++;
      if (dp_valid)           ob_vld++;
      if (drop_at_add && dp_state == 3'b010) begin
        if (ob_g == 1) req1 = 1'b0; else req0 = 1'b0;
      end
      if (change_at_align && dp_state == 3'b001) begin
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;
      end
      if (dp_state == 3'b011) begin
        norm_seen++;
        dp_normalize = (n_norm != 0 && norm_seen >= n_norm);
      end else begin
        dp_normalize = 1'b0;
      end
      if (done0 || done1) begin
        ob_dcnt++;
        ob_done = cyc - ob_load;
        ob_res  = result;
        ob_err  = err;
        if ((done1 ? 1 : 0) != ob_g) ob_wrong = 1;
        fin = 1;
        if (release_after) begin
          if (ob_g == 1) req1 = 1'b0; else req0 = 1'b0;
        end
      end
    end
    dp_normalize = 1'b0;
  endtask

  task automatic idle_gap();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_last = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [45:0] v;
    reset = 1'b0;
    req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v = {gnt0, gnt1, done0, done1, busy, err, dp_en_a, dp_en_b, dp_en_round,
         dp_valid, dp_state, result, dp_a, dp_b, dbg_state};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
    reset = 1'b1;
    req0  = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    int eg;
    a0 = 8'h38; b0 = 8'h38; req0 = 1'b1;
    eg = win(1, 0);
    run_op(2, 8'h40, 1, 0, 0);
    checks++; if (ob_g !== eg) begin errors++; $display("FAIL single_grant: got %0d want %0d", ob_g, eg); end
    checks++; if (ob_load !== 1) begin errors++; $display("FAIL single_load_cycle: got %0d want 1", ob_load); end
    checks++; if (ob_done !== 7) begin errors++; $display("FAIL single_done_offset: got %0d want 7", ob_done); end
    checks++; if (ob_gnt !== 8) begin errors++; $display("FAIL single_gnt_len: got %0d want 8", ob_gnt); end
    checks++; if (ob_res !== 8'h40 || ob_err !== 1'b0) begin errors++; $display("FAIL single_result: got %h/%b want 40/0", ob_res, ob_err); end
    checks++; if (ob_la !== 8'h38 || ob_lb !== 8'h38) begin errors++; $display("FAIL single_operands: got %h/%h want 38/38", ob_la, ob_lb); end
    checks++; if (ob_en !== 1 || ob_rnd !== 1 || ob_vld !== 1) begin errors++; $display("FAIL single_enables: got en=%0d rnd=%0d vld=%0d want 1/1/1", ob_en, ob_rnd, ob_vld); end
    checks++; if (ob_wrong !== 0 || ob_dcnt !== 1) begin errors++; $display("FAIL single_done_owner: got wrong=%0d cnt=%0d want 0/1", ob_wrong, ob_dcnt); end
    idle_gap();
    checks++; if (result !== 8'h40 || busy !== 1'b0) begin errors++; $display("FAIL single_held: got %h busy=%b want 40 busy=0", result, busy); end
  endtask

  task automatic test_timeout();
    int eg;
    a0 = 8'h11; b0 = 8'h22; req0 = 1'b1;
    eg = win(1, 0);
    run_op(0, 8'h5A, 1, 0, 0);
    checks++; if (ob_g !== eg) begin errors++; $display("FAIL timeout_grant: got %0d want %0d", ob_g, eg); end
    checks++; if (ob_done !== exp_done(0)) begin errors++; $display("FAIL timeout_done_offset: got %0d want %0d", ob_done, exp_done(0)); end
    checks++; if (ob_res !== 8'hFF || ob_err !== 1'b1) begin errors++; $display("FAIL timeout_result: got %h/%b want FF/1", ob_res, ob_err); end
    checks++; if (ob_vld !== 0 || ob_rnd !== 0) begin errors++; $display("FAIL timeout_skip: got vld=%0d rnd=%0d want 0/0", ob_vld, ob_rnd); end
    idle_gap();
    checks++; if (result !== 8'hFF || err !== 1'b1) begin errors++; $display("FAIL timeout_held: got %h/%b want FF/1", result, err); end
  endtask

  task automatic test_norm_max_tie();
    a1 = 8'h21; b1 = 8'h43; req1 = 1'b1;
    void'(win(0, 1));
    run_op(NORM_MAX, 8'h6C, 1, 0, 0);
    checks++; if (ob_done !== exp_done(NORM_MAX)) begin errors++; $display("FAIL tie_done_offset: got %0d want %0d", ob_done, exp_done(NORM_MAX)); end
    checks++; if (ob_res !== 8'h6C || ob_err !== 1'b0) begin errors++; $display("FAIL tie_result: got %h/%b want 6C/0", ob_res, ob_err); end
    idle_gap();
  endtask

  task automatic test_req_drop();
    int eg;
    a1 = 8'h0F; b1 = 8'hF0; req1 = 1'b1;
    eg = win(0, 1);
    run_op(1, 8'h33, 0, 1, 0);
    checks++; if (ob_g !== eg || ob_dcnt !== 1 || ob_wrong !== 0) begin errors++; $display("FAIL drop_done: got g=%0d cnt=%0d want g=%0d cnt=1", ob_g, ob_dcnt, eg); end
    checks++; if (ob_done !== exp_done(1) || ob_res !== 8'h33) begin errors++; $display("FAIL drop_timing: got %0d/%h want %0d/33", ob_done, ob_res, exp_done(1)); end
    @(negedge clk);
    checks++; if (gnt1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_gnt_fall: got gnt1=%b busy=%b want 0/0", gnt1, busy); end
    idle_gap();
  endtask

  task automatic test_operand_change();
    a0 = 8'h5C; b0 = 8'h27; req0 = 1'b1;
    void'(win(1, 0));
    run_op(1, 8'h91, 1, 0, 1);
    checks++; if (ob_la !== 8'h5C || ob_lb !== 8'h27) begin errors++; $display("FAIL opchg_load: got %h/%h want 5C/27", ob_la, ob_lb); end
    checks++; if (ob_moved !== 0) begin errors++; $display("FAIL opchg_dp_a_moved: got %0d want 0", ob_moved); end
    checks++; if (ob_res !== 8'h91 || ob_err !== 1'b0) begin errors++; $display("FAIL opchg_result: got %h/%b want 91/0", ob_res, ob_err); end
    idle_gap();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int sel, n, eg;
      logic [7:0] s, ea, eb;
      sel = $urandom_range(0, 2);
      n   = $urandom_range(0, NORM_MAX);
      s   = 8'($urandom_range(0, 255));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      req0 = (sel != 1);
      req1 = (sel != 0);
      eg = win(req0, req1);
      ea = (eg == 1) ? a1 : a0;
      eb = (eg == 1) ? b1 : b0;
      run_op(n, s, 0, 0, 0);
      checks++; if (ob_g !== eg || ob_load !== 1) begin errors++; $display("FAIL rand%0d_grant: got g=%0d load=%0d want g=%0d load=1", i, ob_g, ob_load, eg); end
      checks++; if (ob_done !== exp_done(n)) begin errors++; $display("FAIL rand%0d_done: got %0d want %0d (n=%0d)", i, ob_done, exp_done(n), n); end
      checks++; if (ob_res !== ((n == 0) ? 8'hFF : s) || ob_err !== (n == 0)) begin errors++; $display("FAIL rand%0d_result: got %h/%b want %h/%b", i, ob_res, ob_err, (n == 0) ? 8'hFF : s, n == 0); end
      checks++; if (ob_la !== ea || ob_lb !== eb) begin errors++; $display("FAIL rand%0d_operands: got %h/%h want %h/%h", i, ob_la, ob_lb, ea, eb); end
      checks++; if (ob_vld !== ((n == 0) ? 0 : 1) || ob_both !== 0) begin errors++; $display("FAIL rand%0d_vld_both: got %0d/%0d want %0d/0", i, ob_vld, ob_both, (n == 0) ? 0 : 1); end
      idle_gap();
    end
  endtask

  task automatic test_back_to_back();
    int order[3] = '{0, 1, 0};
    do_reset();
    a0 = 8'h12; b0 = 8'h34; a1 = 8'h56; b1 = 8'h78;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, NORM_MAX);
      void'(win(1, 1));
      run_op(n, 8'(8'h20 + k), 0, 0, 0);
      checks++; if (ob_g !== order[k]) begin errors++; $display("FAIL b2b%0d_grant: got %0d want %0d", k, ob_g, order[k]); end
      checks++; if (ob_load !== ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL b2b%0d_gap: got %0d want %0d", k, ob_load, (k == 0) ? 1 : 2); end
      checks++; if (ob_done !== exp_done(n) || ob_both !== 0) begin errors++; $display("FAIL b2b%0d_done: got %0d both=%0d want %0d both=0", k, ob_done, ob_both, exp_done(n)); end
    end
    idle_gap();
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    bit saw_done = 0;
    logic [45:0] v;
    a0 = 8'h44; b0 = 8'h55; req0 = 1'b1;
    dp_sum = 8'h66;
    dp_normalize = 1'b0;
    while (dp_state !== 3'b011 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (dp_state !== 3'b011) begin errors++; $display("FAIL midrst_reach_norm: got %b want 011", dp_state); end
    #2 reset = 1'b0;
    #1;
    v = {gnt0, gnt1, done0, done1, busy, err, dp_en_a, dp_en_b, dp_en_round,
         dp_valid, dp_state, result, dp_a, dp_b, dbg_state};
    checks++; if (v !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 || done1 || busy) saw_done = 1;
    end
    checks++; if (saw_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", saw_done); end
    reset = 1'b1;
    model_last = 1'b1;
    void'(win(1, 0));
    run_op(1, 8'h77, 1, 0, 0);
    checks++; if (ob_g !== 0 || ob_load !== 1) begin errors++; $display("FAIL midrst_next_grant: got g=%0d load=%0d want 0/1", ob_g, ob_load); end
    checks++; if (ob_done !== exp_done(1) || ob_res !== 8'h77 || ob_err !== 1'b0) begin errors++; $display("FAIL midrst_next_op: got %0d/%h/%b want %0d/77/0", ob_done, ob_res, ob_err, exp_done(1)); end
    idle_gap();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_norm_max_tie();
    test_req_drop();
    test_operand_change();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
